// File: rtl/power_est_pkg.sv
// Shared definitions for the power-estimation current path.
// Holds the setpoint-entry FSM state encoding, the fixed-point format
// constants of the signed current word and a helper that folds three
// decimal fraction digits into one binary value.
package power_est_pkg;

    localparam int CUR_W      = 27;    // signed Q5.22 current word
    localparam int FRAC_W     = 22;    // fraction bits of the current word
    localparam int DEC_SCALE  = 1000;  // three decimal fraction digits
    localparam int ROUND_BIAS = 500;   // half of DEC_SCALE, rounds to nearest

    typedef logic signed [CUR_W-1:0] current_t;

    typedef enum logic [2:0] {
        S_INT,
        S_D1,
        S_D2,
        S_D3,
        S_CONV,
        S_DONE
    } entry_state_t;

    // d1*100 + d2*10 + d3, range 0..999 for valid digits
    function automatic logic [9:0] dec_frac(input logic [3:0] d1,
                                            input logic [3:0] d2,
                                            input logic [3:0] d3);
        return ({6'b0, d1} * 10'd100) + ({6'b0, d2} * 10'd10) + {6'b0, d3};
    endfunction

endpackage

// File: rtl/key_edge.sv
// Push-button conditioning: 2-flop synchronizer followed by a falling-edge
// detector. No debounce; the button is assumed clean.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   key_n      : raw active-low button
//   press      : registered one-cycle pulse, 3 cycles after the raw fall
module key_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    // sh[1:0] is the synchronizer, sh[2] the previous synchronized level
    logic [2:0] sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh    <= '1;
            press <= 1'b0;
        end else begin
            sh    <= {sh[1:0], key_n};
            press <= sh[2] & ~sh[1];
        end
    end

endmodule

// File: rtl/udiv_restoring.sv
// Sequential restoring divider, one quotient bit per cycle.
// The first quotient bit is resolved on the start edge itself, so a
// 32-bit dividend finishes 31 cycles after start and done pulses for one
// cycle with the quotient already stable.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : load dividend/divisor and begin
//   abort      : stop any division in progress, no done pulse
//   dividend   : 32-bit unsigned numerator
//   divisor    : 10-bit unsigned divisor (nonzero)
//   quotient   : low Q_W bits of the quotient (caller guarantees it fits)
//   done       : one-cycle pulse when quotient is final
module udiv_restoring #(
    parameter int Q_W = 22
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [31:0]    dividend,
    input  logic [9:0]     divisor,
    output logic [Q_W-1:0] quotient,
    output logic           done
);

    logic [31:0] dvd;
    logic [9:0]  rem;
    logic [4:0]  cnt;
    logic        run;

    logic [10:0] trial;
    logic [9:0]  rem_nxt;
    logic        q_bit;

    // remainder is always < divisor < 1024, so the restored value fits 10 bits
    always_comb begin
        trial   = start ? {10'b0, dividend[31]} : {rem, dvd[31]};
        q_bit   = 1'b0;
        rem_nxt = trial[9:0];
        if (trial >= {1'b0, divisor}) begin
            q_bit   = 1'b1;
            rem_nxt = 10'(trial - {1'b0, divisor});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            rem      <= '0;
            cnt      <= '0;
            run      <= 1'b0;
            done     <= 1'b0;
            quotient <= '0;
        end else if (abort) begin
            run  <= 1'b0;
            done <= 1'b0;
        end else if (start) begin
            dvd      <= {dividend[30:0], 1'b0};
            rem      <= rem_nxt;
            quotient <= {{(Q_W-1){1'b0}}, q_bit};
            cnt      <= 5'd31;
            run      <= 1'b1;
            done     <= 1'b0;
        end else if (run) begin
            dvd      <= {dvd[30:0], 1'b0};
            rem      <= rem_nxt;
            quotient <= {quotient[Q_W-2:0], q_bit};
            cnt      <= cnt - 5'd1;
            if (cnt == 5'd1) begin
                run  <= 1'b0;
                done <= 1'b1;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/current_setpoint_entry.sv
// Decimal keypad entry of the signed Q5.22 current setpoint.
// Digits are committed in order integer, tenths, hundredths, thousandths;
// the three fraction digits are converted to binary by a restoring divider
// ((frac << FRAC_W) + 500) / 1000 and the signed result is published with
// a one-cycle valid strobe.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_next_n     : raw active-low "commit digit" button
//   key_clear_n    : raw active-low "clear entry" button
//   sw_digit       : digit value on the switches
//   sw_sign        : 1 = negative, sampled on the final digit commit
//   current        : signed Q5.22 setpoint
//   current_valid  : one-cycle pulse when current updates
//   busy           : conversion in progress
//   digit_idx      : next digit expected (0 integer, 1..3 fraction)
//   err            : last commit rejected
module current_setpoint_entry #(
    parameter int FRAC_W  = 22,
    parameter int INT_MAX = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_next_n,
    input  logic        key_clear_n,
    input  logic [3:0]  sw_digit,
    input  logic        sw_sign,
    output logic [26:0] current,
    output logic        current_valid,
    output logic        busy,
    output logic [2:0]  digit_idx,
    output logic        err
);

    import power_est_pkg::*;

    entry_state_t      state;
    logic [3:0]        int_d;
    logic [3:0]        d1;
    logic [3:0]        d2;
    logic              sign_r;

    logic              next_p;
    logic              clr_p;
    logic              dig_ok;
    logic              div_start;
    logic              div_done;
    logic [FRAC_W-1:0] quot;
    logic [31:0]       numer;
    current_t          mag;
    current_t          result;

    key_edge u_key_next (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_next_n),
        .press (next_p)
    );

    key_edge u_key_clear (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_clear_n),
        .press (clr_p)
    );

    always_comb begin
        dig_ok = 1'b0;
        if (state == S_INT) dig_ok = (int'(sw_digit) <= INT_MAX);
        else                dig_ok = (sw_digit <= 4'd9);
    end

    // the thousandths digit feeds the divider straight from the switches
    assign div_start = (state == S_D3) && next_p && !clr_p && dig_ok;
    assign numer     = (32'(dec_frac(d1, d2, sw_digit)) << FRAC_W) + 32'(ROUND_BIAS);

    udiv_restoring #(
        .Q_W (FRAC_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .abort    (clr_p),
        .dividend (numer),
        .divisor  (10'(DEC_SCALE)),
        .quotient (quot),
        .done     (div_done)
    );

    assign mag    = (current_t'(int_d) << FRAC_W) | current_t'(quot);
    assign result = sign_r ? -mag : mag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_INT;
            int_d         <= '0;
            d1            <= '0;
            d2            <= '0;
            sign_r        <= 1'b0;
            current       <= '0;
            current_valid <= 1'b0;
            busy          <= 1'b0;
            digit_idx     <= '0;
            err           <= 1'b0;
        end else begin
            current_valid <= 1'b0;
            if (clr_p) begin
                state     <= S_INT;
                int_d     <= '0;
                d1        <= '0;
                d2        <= '0;
                sign_r    <= 1'b0;
                busy      <= 1'b0;
                digit_idx <= '0;
                err       <= 1'b0;
            end else begin
                case (state)
                    S_INT: if (next_p) begin
                        if (!dig_ok) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            int_d     <= sw_digit;
                            state     <= S_D1;
                            digit_idx <= 3'd1;
                        end
                    end
                    S_D1: if (next_p) begin
                        if (!dig_ok) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            d1        <= sw_digit;
                            state     <= S_D2;
                            digit_idx <= 3'd2;
                        end
                    end
                    S_D2: if (next_p) begin
                        if (!dig_ok) begin
                            err <= 1'b1;
                        end else begin
                            err       <= 1'b0;
                            d2        <= sw_digit;
                            state     <= S_D3;
                            digit_idx <= 3'd3;
                        end
                    end
                    S_D3: if (next_p) begin
                        if (!dig_ok) begin
                            err <= 1'b1;
                        end else begin
                            err    <= 1'b0;
                            sign_r <= sw_sign;
                            state  <= S_CONV;
                            busy   <= 1'b1;
                        end
                    end
                    // The result is registered on the divider's done edge so
                    // it is already visible while the FSM sits in S_DONE;
                    // S_DONE only returns to S_INT.
                    S_CONV: if (div_done) begin
                        current       <= result;
                        current_valid <= 1'b1;
                        busy          <= 1'b0;
                        digit_idx     <= '0;
                        state         <= S_DONE;
                    end
                    S_DONE: state <= S_INT;
                    default: begin
                        state     <= S_INT;
                        busy      <= 1'b0;
                        digit_idx <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_current_setpoint_entry.sv
module tb_current_setpoint_entry;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_next_n = 1'b1;
    logic        key_clear_n = 1'b1;
    logic [3:0]  sw_digit = 4'd0;
    logic        sw_sign = 1'b0;
    logic [26:0] current;
    logic        current_valid;
    logic        busy;
    logic [2:0]  digit_idx;
    logic        err;

    int checks = 0;
    int errors = 0;
    logic [26:0] exp_q[$];
    logic [26:0] last_cur = '0;

    typedef struct {
        logic [3:0]  ip;
        logic [3:0]  d1;
        logic [3:0]  d2;
        logic [3:0]  d3;
        logic        sign;
        logic [26:0] expv;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    current_setpoint_entry #(
        .FRAC_W  (22),
        .INT_MAX (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_next_n    (key_next_n),
        .key_clear_n   (key_clear_n),
        .sw_digit      (sw_digit),
        .sw_sign       (sw_sign),
        .current       (current),
        .current_valid (current_valid),
        .busy          (busy),
        .digit_idx     (digit_idx),
        .err           (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // scoreboard: every valid strobe must match the oldest queued entry
    always @(negedge clk) begin
        if (current_valid) begin
            if (exp_q.size() == 0) chk("valid_with_empty_queue", {31'b0, current_valid}, 32'd0);
            else                   chk("current", {5'b0, current}, {5'b0, exp_q.pop_front()});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_next(input logic [3:0] d);
        sw_digit = d;
        key_next_n = 1'b0;
        cyc(2);
        key_next_n = 1'b1;
        cyc(4);
    endtask

    task automatic press_clear();
        key_clear_n = 1'b0;
        cyc(2);
        key_clear_n = 1'b1;
        cyc(4);
    endtask

    task automatic run_entry(input vec_t v, input string tag);
        int nbusy;
        bit got;
        press_next(v.ip);
        press_next(v.d1);
        press_next(v.d2);
        sw_sign = v.sign;
        exp_q.push_back(v.expv);
        sw_digit = v.d3;
        key_next_n = 1'b0;
        cyc(2);
        key_next_n = 1'b1;
        nbusy = 0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (current_valid) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
        end
        chk({tag, " valid_seen"}, {31'b0, got}, 32'd1);
        chk({tag, " busy_cycles"}, nbusy, 32'd32);
        chk({tag, " busy_at_valid"}, {31'b0, busy}, 32'd0);
        chk({tag, " idx_at_valid"}, {29'b0, digit_idx}, 32'd0);
        @(negedge clk);
        chk({tag, " valid_one_cycle"}, {31'b0, current_valid}, 32'd0);
        chk({tag, " current_hold"}, {5'b0, current}, {5'b0, v.expv});
        last_cur = v.expv;
        cyc(2);
    endtask

    initial begin
        vecs[0] = '{4'd1, 4'd5, 4'd0, 4'd0, 1'b0, 27'h0600000};
        vecs[1] = '{4'd2, 4'd1, 4'd2, 4'd5, 1'b1, 27'h7780000};
        vecs[2] = '{4'd0, 4'd9, 4'd9, 4'd9, 1'b0, 27'd4190110};
        vecs[3] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 27'd0};
        vecs[4] = '{4'd2, 4'd9, 4'd9, 4'd9, 1'b1, 27'd121639010};
        vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd1, 1'b0, 27'd4194};
        vecs[6] = '{4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 27'd130023424};

        cyc(3);
        chk("rst current", {5'b0, current}, 32'd0);
        chk("rst valid", {31'b0, current_valid}, 32'd0);
        chk("rst busy", {31'b0, busy}, 32'd0);
        chk("rst idx", {29'b0, digit_idx}, 32'd0);
        chk("rst err", {31'b0, err}, 32'd0);
        rst_n = 1'b1;
        cyc(3);

        // digit validation
        press_next(4'd3);
        chk("int3 err", {31'b0, err}, 32'd1);
        chk("int3 idx", {29'b0, digit_idx}, 32'd0);
        press_next(4'd2);
        chk("int2 err", {31'b0, err}, 32'd0);
        chk("int2 idx", {29'b0, digit_idx}, 32'd1);
        press_next(4'd12);
        chk("frac12 err", {31'b0, err}, 32'd1);
        chk("frac12 idx", {29'b0, digit_idx}, 32'd1);
        press_clear();
        chk("clr idx", {29'b0, digit_idx}, 32'd0);
        chk("clr err", {31'b0, err}, 32'd0);

        for (int i = 0; i < 7; i++) run_entry(vecs[i], $sformatf("vec%0d", i));

        // clear during conversion
        press_next(4'd1);
        press_next(4'd2);
        press_next(4'd3);
        sw_sign = 1'b0;
        sw_digit = 4'd5;
        key_next_n = 1'b0;
        cyc(2);
        key_next_n = 1'b1;
        cyc(10);
        chk("conv busy", {31'b0, busy}, 32'd1);
        chk("conv idx", {29'b0, digit_idx}, 32'd3);
        press_clear();
        chk("abort busy", {31'b0, busy}, 32'd0);
        chk("abort idx", {29'b0, digit_idx}, 32'd0);
        cyc(50);
        chk("abort current", {5'b0, current}, {5'b0, last_cur});

        // clear and next together in S_D2
        press_next(4'd1);
        press_next(4'd4);
        chk("d2 idx", {29'b0, digit_idx}, 32'd2);
        sw_digit = 4'd7;
        key_next_n = 1'b0;
        key_clear_n = 1'b0;
        cyc(2);
        key_next_n = 1'b1;
        key_clear_n = 1'b1;
        cyc(4);
        chk("both idx", {29'b0, digit_idx}, 32'd0);
        chk("both err", {31'b0, err}, 32'd0);
        chk("both current", {5'b0, current}, {5'b0, last_cur});
        press_next(4'd1);
        chk("after both idx", {29'b0, digit_idx}, 32'd1);
        press_clear();

        // reset mid-conversion
        press_next(4'd2);
        press_next(4'd3);
        press_next(4'd3);
        sw_sign = 1'b1;
        sw_digit = 4'd3;
        key_next_n = 1'b0;
        cyc(2);
        key_next_n = 1'b1;
        cyc(12);
        chk("pre-rst busy", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid-rst current", {5'b0, current}, 32'd0);
        chk("mid-rst valid", {31'b0, current_valid}, 32'd0);
        chk("mid-rst busy", {31'b0, busy}, 32'd0);
        chk("mid-rst idx", {29'b0, digit_idx}, 32'd0);
        chk("mid-rst err", {31'b0, err}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(50);
        chk("post-rst current", {5'b0, current}, 32'd0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
